// File: rtl/va_to_pa_pkg.sv
// Shared types and constants for the va_to_pa page-table walker.
package va_to_pa_pkg;

  localparam int LEVELS         = 4;
  localparam int IDX_BITS       = 9;
  localparam int PAGE_SHIFT     = 12;
  localparam int PTE_PPN_LSB    = 10;
  localparam int PTE_V_BIT      = 0;
  localparam logic [12:0] READ_TAG = 13'h1100;
  localparam int BEATS_PER_LINE = 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ARB,
    W_WALK,
    W_DONE
  } walk_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_RESP
  } rd_state_t;

  // Table index for a level, taken from the VPN field VA[47:12].
  function automatic logic [IDX_BITS-1:0] va_index(
    input logic [IDX_BITS*LEVELS-1:0] vpn,
    input logic [1:0]                 level
  );
    return vpn[IDX_BITS*level +: IDX_BITS];
  endfunction

endpackage

// File: rtl/va_to_pa_bus_line_reader.sv
// One 64-byte line read on the system bus: request handshake, then eight
// response beats assembled into a 512-bit line.
module bus_line_reader
  import va_to_pa_pkg::*;
#(
  parameter int                      BUS_DATA_WIDTH = 64,
  parameter int                      BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-1:0] REQ_TAG       = 13'h1100
)(
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     i_start,
  input  logic [BUS_DATA_WIDTH-1:0]                i_addr,
  output logic                                     o_done,
  output logic [BUS_DATA_WIDTH*BEATS_PER_LINE-1:0] o_line,
  output logic                                     o_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]                o_req,
  output logic [BUS_TAG_WIDTH-1:0]                 o_reqtag,
  input  logic                                     i_reqack,
  input  logic                                     i_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]                i_resp,
  output logic                                     o_respack
);

  localparam int BEAT_W = $clog2(BEATS_PER_LINE);

  rd_state_t                               r_state;
  rd_state_t                               w_state_nxt;
  logic [BEAT_W-1:0]                       r_beat;
  logic [BUS_DATA_WIDTH*BEATS_PER_LINE-1:0] r_line;
  logic                                    w_beat_acc;
  logic                                    w_last;
  logic                                    w_unused;

  assign w_beat_acc = (r_state == R_RESP) && i_respcyc;
  assign w_last     = w_beat_acc && (r_beat == BEAT_W'(BEATS_PER_LINE - 1));
  assign o_done     = w_last;
  assign w_unused   = ^i_addr[5:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_start)
        r_beat <= '0;
      else if (w_beat_acc)
        r_beat <= r_beat + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat_acc)
      r_line[r_beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= i_resp;
  end

  // A new read may be chained in the same cycle the last beat lands.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (i_start) w_state_nxt = R_REQ;
      R_REQ:   if (i_reqack) w_state_nxt = R_RESP;
      R_RESP:  if (w_last) w_state_nxt = i_start ? R_REQ : R_IDLE;
      default: w_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    o_reqcyc  = 1'b0;
    o_req     = '0;
    o_reqtag  = '0;
    o_respack = 1'b0;
    o_line    = r_line;
    if (r_state == R_REQ) begin
      o_reqcyc = 1'b1;
      o_req    = {i_addr[BUS_DATA_WIDTH-1:6], 6'b0};
      o_reqtag = REQ_TAG;
    end
    if (r_state == R_RESP) begin
      o_respack = i_respcyc;
      if (i_respcyc)
        o_line[r_beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = i_resp;
    end
  end

endmodule

// File: rtl/va_to_pa.sv
// 4-level Sv48-style page-table walker returning the leaf PTE line to the TLB.
// Optional: define VA_TO_PA_VALID_CHECK_EN to abort the walk on a PTE with V=0.
module va_to_pa #(
  parameter int                      BUS_DATA_WIDTH = 64,
  parameter int                      BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG      = 13'h1100,
  parameter int                      LEVELS         = 4
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [63:0]                 ptbr,
  input  logic                        enable,
  input  logic [63:0]                 virt_addr,
  input  logic                        abtr_grant,
  output logic                        abtr_reqcyc,
  output logic                        bus_busy,
  output logic                        main_bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]   main_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    main_bus_reqtag,
  input  logic                        main_bus_reqack,
  input  logic                        main_bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]   main_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]    main_bus_resptag,
  output logic                        main_bus_respack,
  output logic [BUS_DATA_WIDTH*va_to_pa_pkg::BEATS_PER_LINE-1:0] phy_addr_array,
  output logic                        ready
);

  import va_to_pa_pkg::IDX_BITS;
  import va_to_pa_pkg::PAGE_SHIFT;
  import va_to_pa_pkg::PTE_PPN_LSB;
  import va_to_pa_pkg::PTE_V_BIT;
  import va_to_pa_pkg::BEATS_PER_LINE;
  import va_to_pa_pkg::walk_state_t;
  import va_to_pa_pkg::W_IDLE;
  import va_to_pa_pkg::W_ARB;
  import va_to_pa_pkg::W_WALK;
  import va_to_pa_pkg::W_DONE;
  import va_to_pa_pkg::va_index;

  localparam int LINE_W = BUS_DATA_WIDTH * BEATS_PER_LINE;
  localparam int VPN_W  = IDX_BITS * LEVELS;

  walk_state_t               r_state;
  walk_state_t               w_state_nxt;
  logic [1:0]                r_level;
  logic [VPN_W-1:0]          r_vpn;
  logic [BUS_DATA_WIDTH-1:0] r_base;
  logic [LINE_W-1:0]         r_phy;
  logic                      w_rd_start;
  logic                      w_rd_done;
  logic [LINE_W-1:0]         w_line;
  logic [BUS_DATA_WIDTH-1:0] w_pte_addr;
  logic [BUS_DATA_WIDTH-1:0] w_pte;
  logic                      w_pte_valid;
  logic                      w_unused;

  assign w_pte_addr = r_base + {{(BUS_DATA_WIDTH-IDX_BITS-3){1'b0}}, va_index(r_vpn, r_level), 3'b000};
  assign w_pte      = w_line[w_pte_addr[5:3]*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];

`ifdef VA_TO_PA_VALID_CHECK_EN
  assign w_pte_valid = w_pte[PTE_V_BIT];
`else
  assign w_pte_valid = 1'b1;
`endif

  assign w_unused = ^{ptbr[63:52], virt_addr[63:PAGE_SHIFT+VPN_W], virt_addr[PAGE_SHIFT-1:0],
                      main_bus_resptag, w_pte[PTE_PPN_LSB-1:0], w_pte[63:62], w_pte[PTE_V_BIT]};

  assign phy_addr_array = r_phy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= W_IDLE;
      r_level <= '0;
      r_vpn   <= '0;
      r_base  <= '0;
      r_phy   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == W_IDLE && enable) begin
        r_vpn   <= virt_addr[PAGE_SHIFT +: VPN_W];
        r_level <= 2'(LEVELS - 1);
        r_base  <= {ptbr[51:0], 12'b0};
      end
      // Beat 7 just landed: the selected PTE either ends the walk or seeds the next level.
      if (r_state == W_WALK && w_rd_done) begin
        if (!w_pte_valid)
          r_phy <= '0;
        else if (r_level == 2'd0)
          r_phy <= w_line;
        else begin
          r_level <= r_level - 2'd1;
          r_base  <= {w_pte[BUS_DATA_WIDTH-PAGE_SHIFT+PTE_PPN_LSB-1:PTE_PPN_LSB], 12'b0};
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    abtr_reqcyc = 1'b0;
    bus_busy    = 1'b0;
    ready       = 1'b0;
    w_rd_start  = 1'b0;
    case (r_state)
      W_IDLE: if (enable) w_state_nxt = W_ARB;
      W_ARB: begin
        abtr_reqcyc = 1'b1;
        if (abtr_grant) begin
          bus_busy    = 1'b1;
          w_rd_start  = 1'b1;
          w_state_nxt = W_WALK;
        end
      end
      W_WALK: begin
        abtr_reqcyc = 1'b1;
        bus_busy    = 1'b1;
        if (w_rd_done) begin
          if (!w_pte_valid || r_level == 2'd0)
            w_state_nxt = W_DONE;
          else
            w_rd_start = 1'b1;
        end
      end
      W_DONE: begin
        abtr_reqcyc = 1'b1;
        bus_busy    = 1'b1;
        ready       = 1'b1;
        w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  bus_line_reader #(
    .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
    .BUS_TAG_WIDTH  (BUS_TAG_WIDTH),
    .REQ_TAG        (READ_TAG)
  ) u_reader (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_rd_start),
    .i_addr    (w_pte_addr),
    .o_done    (w_rd_done),
    .o_line    (w_line),
    .o_reqcyc  (main_bus_reqcyc),
    .o_req     (main_bus_req),
    .o_reqtag  (main_bus_reqtag),
    .i_reqack  (main_bus_reqack),
    .i_respcyc (main_bus_respcyc),
    .i_resp    (main_bus_resp),
    .o_respack (main_bus_respack)
  );

endmodule

// File: tb/tb_va_to_pa.sv
// Self-checking bench for va_to_pa: memory responder, arbiter driver and a
// behavioural walk model over a sparse word memory.
`timescale 1ns/1ps
module tb_va_to_pa;

  localparam logic [12:0] READ_TAG  = 13'h1100;
  localparam logic [63:0] VA_BASIC  = 64'h0000_0040_0020_3000;
  localparam logic [63:0] VA_OTHER  = 64'h0000_0040_0040_3000;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  ptbr;
  logic         enable;
  logic [63:0]  virt_addr;
  logic         abtr_grant;
  logic         abtr_reqcyc;
  logic         bus_busy;
  logic         main_bus_reqcyc;
  logic [63:0]  main_bus_req;
  logic [12:0]  main_bus_reqtag;
  logic         main_bus_reqack;
  logic         main_bus_respcyc;
  logic [63:0]  main_bus_resp;
  logic [12:0]  main_bus_resptag;
  logic         main_bus_respack;
  logic [511:0] phy_addr_array;
  logic         ready;

  va_to_pa dut (
    .clk              (clk),
    .reset            (reset),
    .ptbr             (ptbr),
    .enable           (enable),
    .virt_addr        (virt_addr),
    .abtr_grant       (abtr_grant),
    .abtr_reqcyc      (abtr_reqcyc),
    .bus_busy         (bus_busy),
    .main_bus_reqcyc  (main_bus_reqcyc),
    .main_bus_req     (main_bus_req),
    .main_bus_reqtag  (main_bus_reqtag),
    .main_bus_reqack  (main_bus_reqack),
    .main_bus_respcyc (main_bus_respcyc),
    .main_bus_resp    (main_bus_resp),
    .main_bus_resptag (main_bus_resptag),
    .main_bus_respack (main_bus_respack),
    .phy_addr_array   (phy_addr_array),
    .ready            (ready)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [63:0]  mem [logic [63:0]];
  logic [63:0]  exp_addr [$];
  int           ack_dly_cfg = -1;
  int           n_reads = 0;
  int           n_beats = 0;
  logic [511:0] prev_line = '0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    logic [63:0] k;
    k = {a[63:3], 3'b000};
    if (mem.exists(k)) return mem[k];
    return (k * 64'h9E37_79B9_7F4A_7C15) ^ (k >> 17);
  endfunction

  // Walk from the rules: addr = base + idx*8, next base = PPN<<12, leaf line returned.
  task automatic model_walk(input logic [63:0] p, input logic [63:0] va, output logic [511:0] line);
    logic [63:0] base, a, pte;
    logic [8:0]  idx;
    line = '0;
    base = p << 12;
    for (int l = 3; l >= 0; l--) begin
      idx = va[12 + 9*l +: 9];
      a   = base + 64'(idx) * 64'd8;
      exp_addr.push_back({a[63:6], 6'b0});
      pte = mem_rd(a);
`ifdef VA_TO_PA_VALID_CHECK_EN
      if (!pte[0]) break;
`endif
      if (l == 0)
        for (int w = 0; w < 8; w++) line[64*w +: 64] = mem_rd({a[63:6], 6'b0} + 64'(8*w));
      base = (pte >> 10) << 12;
    end
  endtask

  task automatic serve_read();
    logic [63:0] a, e;
    int d;
    a = main_bus_req;
    n_reads++;
    n_beats = 0;
    chk("req_tag", main_bus_reqtag, READ_TAG);
    chk("req_expected", exp_addr.size() > 0, 1'b1);
    if (exp_addr.size() > 0) begin
      e = exp_addr.pop_front();
      chk("req_addr", a, e);
    end
    d = (ack_dly_cfg < 0) ? int'($urandom_range(0, 3)) : ack_dly_cfg;
    repeat (d) begin
      tick();
      if (reset) return;
      chk("req_hold", {main_bus_reqcyc, main_bus_reqtag, main_bus_req}, {1'b1, READ_TAG, a});
    end
    main_bus_reqack = 1'b1;
    tick();
    main_bus_reqack = 1'b0;
    if (reset) return;
    chk("reqcyc_drop", main_bus_reqcyc, 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        if (reset) return;
      end
      main_bus_respcyc = 1'b1;
      main_bus_resp    = mem_rd({a[63:6], 6'b0} + 64'(8*k));
      #1;
      chk("respack_on_beat", main_bus_respack, 1'b1);
      tick();
      main_bus_respcyc = 1'b0;
      n_beats = k + 1;
      if (reset) return;
    end
  endtask

  initial begin : responder
    main_bus_reqack  = 1'b0;
    main_bus_respcyc = 1'b0;
    main_bus_resp    = '0;
    main_bus_resptag = READ_TAG;
    forever begin
      tick();
      if (!reset && main_bus_reqcyc) serve_read();
    end
  end

  initial begin : respack_mon
    forever begin
      tick();
      #1;
      if (main_bus_respack) chk("respack_wo_respcyc", main_bus_respcyc, 1'b1);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic run_walk(input string name, input logic [63:0] p, input logic [63:0] va,
                          input int gdly, input logic hold_en);
    logic [511:0] exp_line;
    int t;
    exp_addr.delete();
    model_walk(p, va, exp_line);
    ptbr      = p;
    virt_addr = va;
    enable    = 1'b1;
    tick();
    enable    = hold_en;
    virt_addr = {$urandom, $urandom};
    ptbr      = {$urandom, $urandom};
    chk("arb_req", {abtr_reqcyc, bus_busy}, 2'b10);
    repeat (gdly) begin
      tick();
      chk("arb_hold", {abtr_reqcyc, bus_busy, main_bus_reqcyc}, 3'b100);
    end
    abtr_grant = 1'b1;
    #1;
    chk("busy_at_grant", bus_busy, 1'b1);
    tick();
    abtr_grant = 1'b0;
    t = 0;
    while (!ready && t < 1000) begin
      chk("phy_hold", phy_addr_array, prev_line);
      tick();
      t++;
    end
    chk({name, "_ready_seen"}, ready, 1'b1);
    if (ready) begin
      chk({name, "_line"}, phy_addr_array, exp_line);
      chk("done_bus_held", {abtr_reqcyc, bus_busy}, 2'b11);
      chk("reads_left", exp_addr.size(), 0);
      prev_line = exp_line;
    end
    tick();
    enable = 1'b0;
    chk("ready_pulse", ready, 1'b0);
    chk("no_restart", abtr_reqcyc, 1'b0);
    chk("phy_keep", phy_addr_array, prev_line);
  endtask

  initial begin : main
    logic [511:0] tmp;
    int r0, t;
    reset      = 1'b1;
    ptbr       = '0;
    enable     = 1'b0;
    virt_addr  = '0;
    abtr_grant = 1'b0;

    mem[64'h1000] = (64'h2 << 10) | 64'h1;
    mem[64'h2800] = (64'h3 << 10) | 64'h1;
    mem[64'h3008] = (64'h4 << 10) | 64'h1;
    for (int i = 0; i < 8; i++) mem[64'h4000 + 64'(8*i)] = 64'(16 + i) << 10;

    tick();
    tick();
    chk("rst_outputs", {abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_req, main_bus_reqtag,
                        main_bus_respack, ready}, '0);
    chk("rst_phy", phy_addr_array, '0);
    reset = 1'b0;
    tick();

    run_walk("basic", 64'h1, VA_BASIC, 0, 1'b0);
`ifndef VA_TO_PA_VALID_CHECK_EN
    for (int i = 0; i < 8; i++) chk("leaf_word", phy_addr_array[64*i +: 64], 64'(16 + i) << 10);
`endif

    ack_dly_cfg = 3;
    run_walk("handshake", 64'h1, VA_OTHER, 5, 1'b1);
    ack_dly_cfg = -1;

    run_walk("back_to_back", 64'h1, VA_BASIC, 1, 1'b1);

    for (int n = 0; n < 6; n++)
      run_walk("random", 64'($urandom_range(0, 16'hFFFF)), {$urandom, $urandom},
               int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));

    // Abort a walk with reset partway through the second level's line.
    exp_addr.delete();
    model_walk(64'h1, VA_BASIC, tmp);
    r0        = n_reads;
    ptbr      = 64'h1;
    virt_addr = VA_BASIC;
    enable    = 1'b1;
    tick();
    enable     = 1'b0;
    abtr_grant = 1'b1;
    tick();
    abtr_grant = 1'b0;
    t = 0;
    while (!(n_reads == r0 + 2 && n_beats >= 4) && t < 500) begin
      tick();
      t++;
    end
    chk("abort_point", n_reads - r0, 2);
    reset = 1'b1;
    tick();
    chk("abort_outputs", {abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_req, main_bus_reqtag,
                          main_bus_respack, ready}, '0);
    chk("abort_phy", phy_addr_array, '0);
    tick();
    reset = 1'b0;
    prev_line = '0;
    tick();
    chk("abort_idle", abtr_reqcyc, 1'b0);
    run_walk("after_reset", 64'h1, VA_BASIC, 2, 1'b0);

`ifdef VA_TO_PA_VALID_CHECK_EN
    mem[64'h2800] = 64'h0;
    r0 = n_reads;
    run_walk("invalid_l2", 64'h1, VA_BASIC, 0, 1'b0);
    chk("invalid_l2_reads", n_reads - r0, 2);
    chk("invalid_l2_zero", phy_addr_array, '0);
    mem[64'h2800] = (64'h3 << 10) | 64'h1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
